// File: rtl/echo_indication_buffer.sv
// Heard-indication consumer: DEPTH-entry FIFO with guarded enq/first/deq methods,
// a wrap-around count of accepted indications and an occupancy output.
module echo_indication_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     heard__ENA,
    input  logic [WIDTH-1:0]         heard_v,
    output logic                     heard__RDY,
    output logic [WIDTH-1:0]         out_first,
    output logic                     out_first__RDY,
    input  logic                     out_deq__ENA,
    output logic                     out_deq__RDY,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         heard_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             enq_fire;
    logic             deq_fire;

    // Guards depend only on the registered level, so a full FIFO never accepts
    // an enqueue even if the sink dequeues in the same cycle.
    assign heard__RDY     = (level != FULL_LVL);
    assign out_first__RDY = (level != '0);
    assign out_deq__RDY   = out_first__RDY;
    assign out_first      = mem[rd_ptr];

    assign enq_fire = heard__ENA & heard__RDY;
    assign deq_fire = out_deq__ENA & out_deq__RDY;

    always_ff @(posedge CLK) begin
        if (nRST) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            heard_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (enq_fire) begin
                mem[wr_ptr] <= heard_v;
                wr_ptr      <= wr_ptr + PTR_W'(1);
                heard_count <= heard_count + CNT_W'(1);
            end
            if (deq_fire) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({enq_fire, deq_fire})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_echo_indication_buffer.sv
// Directed, table-driven bench for echo_indication_buffer (DEPTH=4, CNT_W=4 so the
// indication counter wrap is reachable in a short run).
module tb_echo_indication_buffer;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic             CLK = 1'b0;
    logic             nRST;
    logic             heard__ENA;
    logic [WIDTH-1:0] heard_v;
    logic             heard__RDY;
    logic [WIDTH-1:0] out_first;
    logic             out_first__RDY;
    logic             out_deq__ENA;
    logic             out_deq__RDY;
    logic [2:0]       level;
    logic [CNT_W-1:0] heard_count;

    int total = 0;
    int bad   = 0;

    echo_indication_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .heard__ENA     (heard__ENA),
        .heard_v        (heard_v),
        .heard__RDY     (heard__RDY),
        .out_first      (out_first),
        .out_first__RDY (out_first__RDY),
        .out_deq__ENA   (out_deq__ENA),
        .out_deq__RDY   (out_deq__RDY),
        .level          (level),
        .heard_count    (heard_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        ena;
        logic [31:0] v;
        logic        deq;
        logic        rdy;
        logic        frdy;
        logic        chkf;
        logic [31:0] first;
        logic [2:0]  lvl;
        logic [3:0]  cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Apply inputs, clock once, sample 1ns after the edge.
    task automatic step(input logic rst, input logic ena, input logic [31:0] v, input logic deq);
        nRST         = rst;
        heard__ENA   = ena;
        heard_v      = v;
        out_deq__ENA = deq;
        @(posedge CLK);
        #1;
        nRST         = 1'b0;
        heard__ENA   = 1'b0;
        heard_v      = '0;
        out_deq__ENA = 1'b0;
    endtask

    task automatic chk_state(input string tag, input logic rdy, input logic frdy,
                             input logic [2:0] lvl, input logic [3:0] cnt);
        chk({tag, ".heard_rdy"}, 32'(heard__RDY), 32'(rdy));
        chk({tag, ".first_rdy"}, 32'(out_first__RDY), 32'(frdy));
        chk({tag, ".deq_rdy"}, 32'(out_deq__RDY), 32'(frdy));
        chk({tag, ".level"}, 32'(level), 32'(lvl));
        chk({tag, ".count"}, 32'(heard_count), 32'(cnt));
    endtask

    logic [31:0] model_q[$];
    logic [31:0] d;

    initial begin
        nRST = 1'b0; heard__ENA = 1'b0; heard_v = '0; out_deq__ENA = 1'b0;

        //        rst  ena  v             deq   rdy  frdy chkf first         lvl cnt
        // reset with ENA held
        vecs.push_back('{1'b1,1'b1,32'h11,       1'b0, 1'b1,1'b0,1'b0,32'h0,       3'd0,4'd0});
        vecs.push_back('{1'b1,1'b1,32'h12,       1'b0, 1'b1,1'b0,1'b0,32'h0,       3'd0,4'd0});
        // single pass
        vecs.push_back('{1'b0,1'b1,32'hDEADBEEF, 1'b0, 1'b1,1'b1,1'b1,32'hDEADBEEF,3'd1,4'd1});
        vecs.push_back('{1'b0,1'b0,32'h0,        1'b1, 1'b1,1'b0,1'b0,32'h0,       3'd0,4'd1});
        // dequeue while empty is ignored
        vecs.push_back('{1'b0,1'b0,32'h0,        1'b1, 1'b1,1'b0,1'b0,32'h0,       3'd0,4'd1});
        // fill, ignored enq while full, drain
        vecs.push_back('{1'b1,1'b0,32'h0,        1'b0, 1'b1,1'b0,1'b0,32'h0,       3'd0,4'd0});
        vecs.push_back('{1'b0,1'b1,32'h1,        1'b0, 1'b1,1'b1,1'b1,32'h1,       3'd1,4'd1});
        vecs.push_back('{1'b0,1'b1,32'h2,        1'b0, 1'b1,1'b1,1'b1,32'h1,       3'd2,4'd2});
        vecs.push_back('{1'b0,1'b1,32'h3,        1'b0, 1'b1,1'b1,1'b1,32'h1,       3'd3,4'd3});
        vecs.push_back('{1'b0,1'b1,32'h4,        1'b0, 1'b0,1'b1,1'b1,32'h1,       3'd4,4'd4});
        vecs.push_back('{1'b0,1'b1,32'h5,        1'b0, 1'b0,1'b1,1'b1,32'h1,       3'd4,4'd4});
        vecs.push_back('{1'b0,1'b0,32'h0,        1'b1, 1'b1,1'b1,1'b1,32'h2,       3'd3,4'd4});
        vecs.push_back('{1'b0,1'b0,32'h0,        1'b1, 1'b1,1'b1,1'b1,32'h3,       3'd2,4'd4});
        vecs.push_back('{1'b0,1'b0,32'h0,        1'b1, 1'b1,1'b1,1'b1,32'h4,       3'd1,4'd4});
        vecs.push_back('{1'b0,1'b0,32'h0,        1'b1, 1'b1,1'b0,1'b0,32'h0,       3'd0,4'd4});
        // simultaneous enq+deq at level 2, then ENA+deq while full
        vecs.push_back('{1'b0,1'b1,32'h21,       1'b0, 1'b1,1'b1,1'b1,32'h21,      3'd1,4'd5});
        vecs.push_back('{1'b0,1'b1,32'h22,       1'b0, 1'b1,1'b1,1'b1,32'h21,      3'd2,4'd6});
        vecs.push_back('{1'b0,1'b1,32'hA,        1'b1, 1'b1,1'b1,1'b1,32'h22,      3'd2,4'd7});
        vecs.push_back('{1'b0,1'b1,32'h23,       1'b0, 1'b1,1'b1,1'b1,32'h22,      3'd3,4'd8});
        vecs.push_back('{1'b0,1'b1,32'h24,       1'b0, 1'b0,1'b1,1'b1,32'h22,      3'd4,4'd9});
        vecs.push_back('{1'b0,1'b1,32'h25,       1'b1, 1'b1,1'b1,1'b1,32'hA,       3'd3,4'd9});
        vecs.push_back('{1'b0,1'b0,32'h0,        1'b1, 1'b1,1'b1,1'b1,32'h23,      3'd2,4'd9});
        vecs.push_back('{1'b0,1'b0,32'h0,        1'b1, 1'b1,1'b1,1'b1,32'h24,      3'd1,4'd9});
        vecs.push_back('{1'b0,1'b0,32'h0,        1'b1, 1'b1,1'b0,1'b0,32'h0,       3'd0,4'd9});

        repeat (2) @(posedge CLK);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].ena, vecs[i].v, vecs[i].deq);
            chk_state($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].frdy, vecs[i].lvl, vecs[i].cnt);
            if (vecs[i].chkf) chk($sformatf("vec%0d.first", i), out_first, vecs[i].first);
        end

        // Pointer and counter wrap: 20 enq/deq pairs, order checked against a queue.
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk_state("wrap.reset", 1'b1, 1'b0, 3'd0, 4'd0);
        for (int i = 0; i < 20; i++) begin
            d = 32'h1000_0000 + 32'(i) * 32'h0101_0101 + 32'(i * 7);
            model_q.push_back(d);
            step(1'b0, 1'b1, d, 1'b0);
            if (i % 2 == 0) begin
                chk($sformatf("wrap%0d.level", i), 32'(level), 32'd1);
                chk($sformatf("wrap%0d.first", i), out_first, model_q[0]);
                step(1'b0, 1'b0, 32'h0, 1'b1);
                void'(model_q.pop_front());
                chk($sformatf("wrap%0d.level_after", i), 32'(level), 32'd0);
            end else begin
                // keep one extra entry in flight, then retire two with enq+deq overlap
                d = ~d;
                model_q.push_back(d);
                step(1'b0, 1'b1, d, 1'b1);
                chk($sformatf("wrap%0d.first_ov", i), out_first, model_q[1]);
                void'(model_q.pop_front());
                chk($sformatf("wrap%0d.level_ov", i), 32'(level), 32'd1);
                step(1'b0, 1'b0, 32'h0, 1'b1);
                void'(model_q.pop_front());
                chk($sformatf("wrap%0d.level_after", i), 32'(level), 32'd0);
            end
        end
        // 20 single enqueues plus 10 overlapped ones = 30 accepted, 30 mod 16 = 14
        chk_state("wrap.end", 1'b1, 1'b0, 3'd0, 4'd14);

        // Mid-operation reset discards stored data.
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h61, 1'b0);
        step(1'b0, 1'b1, 32'h62, 1'b0);
        step(1'b0, 1'b1, 32'h63, 1'b0);
        chk_state("mid.pre", 1'b1, 1'b1, 3'd3, 4'd3);
        step(1'b1, 1'b1, 32'h64, 1'b1);
        chk_state("mid.rst", 1'b1, 1'b0, 3'd0, 4'd0);
        step(1'b0, 1'b1, 32'h55, 1'b0);
        chk_state("mid.enq", 1'b1, 1'b1, 3'd1, 4'd1);
        chk("mid.first55", out_first, 32'h55);
        step(1'b0, 1'b1, 32'h56, 1'b1);
        chk("mid.first56", out_first, 32'h56);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk_state("mid.end", 1'b1, 1'b0, 3'd0, 4'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
